bla_sub_serial: RTL and testbench



---
 rtl/bla_sub_serial_pkg.sv | 12 +
 rtl/bla_4b.sv | 32 +++
 rtl/bla_sub_serial.sv | 111 +++++++++++
 tb/tb_bla_sub_serial.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bla_sub_serial_pkg.sv
// Shared constants and state encoding for the nibble-serial subtractor.
package bla_sub_serial_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bla_4b.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - br_in.
module bla_4b
  import bla_sub_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               br_in,
  output logic [SLICE_W-1:0] d,
  output logic               br_out
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   br;

  // Borrow generate when a_i=0,b_i=1; propagate when a_i==b_i.
  always_comb begin
    g = ~a & b;
    p = ~(a ^ b);
    br[0] = br_in;
    br[1] = g[0] | (p[0] & br_in);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & br_in);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & br_in);
    d      = a ^ b ^ br[SLICE_W-1:0];
    br_out = br[SLICE_W];
  end

endmodule

// File: rtl/bla_sub_serial.sv
// Nibble-serial subtractor: diff = a - b - b_in, one 4-bit slice per clock.
// Optional SUB_OVF_FLAG_EN adds a two's-complement overflow output (ovf).
module bla_sub_serial
  import bla_sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB   = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               consume;
  logic               last;
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] sd;
  logic               sbr;

  assign accept  = (state == ST_IDLE) & in_valid & in_ready;
  assign consume = (state == ST_DONE) & out_valid & out_ready;
  assign last    = (cnt == CNT_W'(NIB - 1));
  assign sa      = a_q[cnt*SLICE_W +: SLICE_W];
  assign sb      = b_q[cnt*SLICE_W +: SLICE_W];

  bla_4b u_slice (
    .a      (sa),
    .b      (sb),
    .br_in  (br_q),
    .d      (sd),
    .br_out (sbr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)          state_nxt = ST_RUN;
      ST_RUN:  if (last)            state_nxt = ST_DONE;
      ST_DONE: if (consume)         state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-slice datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      br_q      <= 1'b0;
      cnt       <= '0;
`ifdef SUB_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      in_ready <= (state_nxt == ST_IDLE);
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        br_q <= b_in;
        cnt  <= '0;
      end
      if (state == ST_RUN) begin
        diff[cnt*SLICE_W +: SLICE_W] <= sd;
        br_q <= sbr;
        cnt  <= cnt + CNT_W'(1);
        if (last) begin
          out_valid <= 1'b1;
          b_out     <= sbr;
`ifdef SUB_OVF_FLAG_EN
          ovf <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sd[SLICE_W-1] ^ a_q[WIDTH-1]);
`endif
        end
      end
      if (consume) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bla_sub_serial.sv
// Self-checking bench for bla_sub_serial (WIDTH=16) with a result scoreboard.
module tb_bla_sub_serial;

  localparam int unsigned W   = 16;
  localparam int          NIB = W / 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SUB_OVF_FLAG_EN
  logic         ovf;
`endif

  int   errors;
  int   checks;
  exp_t sb_q[$];

  bla_sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One full transaction: accept, latency, result vs scoreboard, hold, consume.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input int hold);
    exp_t         e;
    exp_t         got;
    logic [W:0]   full;
    int           n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL in_ready_wait got=%b exp=1", in_ready); errors++;
    end
    a = ta; b = tb_v; b_in = tbin; in_valid = 1'b1;
    full  = {1'b0, ta} - {1'b0, tb_v} - (W+1)'(tbin);
    e.diff = full[W-1:0];
    e.bo   = full[W];
    e.ovf  = (ta[W-1] != tb_v[W-1]) && (full[W-1] != ta[W-1]);
    sb_q.push_back(e);
    @(posedge clk); #1;
    // Keep in_valid high with junk operands; they must be ignored outside IDLE.
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL in_ready_busy got=%b exp=0", in_ready); errors++;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != NIB || out_valid !== 1'b1) begin
      $display("FAIL latency got=%0d exp=%0d", n, NIB); errors++;
    end
    got.diff = diff; got.bo = b_out; got.ovf = 1'b0;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty got=0 exp>0");
      e = got;
    end else begin
      e = sb_q.pop_front();
    end
    checks++;
    if (diff !== e.diff) begin
      $display("FAIL diff a=%h b=%h bin=%b got=%h exp=%h", ta, tb_v, tbin, diff, e.diff); errors++;
    end
    checks++;
    if (b_out !== e.bo) begin
      $display("FAIL b_out a=%h b=%h bin=%b got=%b exp=%b", ta, tb_v, tbin, b_out, e.bo); errors++;
    end
`ifdef SUB_OVF_FLAG_EN
    checks++;
    if (ovf !== e.ovf) begin
      $display("FAIL ovf a=%h b=%h got=%b exp=%b", ta, tb_v, ovf, e.ovf); errors++;
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== e.diff || b_out !== e.bo || in_ready !== 1'b0) begin
        $display("FAIL hold cyc=%0d got v=%b d=%h bo=%b rdy=%b exp v=1 d=%h bo=%b rdy=0",
                 i, out_valid, diff, b_out, in_ready, e.diff, e.bo);
        errors++;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL consume got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
      $display("FAIL reset_vals got rdy=%b v=%b d=%h bo=%b exp 0 0 0000 0",
               in_ready, out_valid, diff, b_out);
      errors++;
    end
`ifdef SUB_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      $display("FAIL reset_ovf got=%b exp=0", ovf); errors++;
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); errors++;
    end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h1000, 16'h0001, 1'b0, 0);
    run_op(16'h5555, 16'h5555, 1'b1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h0000, 16'hFFFF, 1'b1, 0);
  endtask

  task automatic test_hold();
    run_op(16'hABCD, 16'h1234, 1'b1, 10);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a = 16'hFFFF; b = 16'h1111; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== '0 || b_out !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL mid_reset got v=%b d=%h bo=%b rdy=%b exp 0 0000 0 0",
               out_valid, diff, b_out, in_ready);
      errors++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL mid_reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); errors++;
    end
    run_op(16'h00FF, 16'h000F, 1'b0, 0);
  endtask

  task automatic test_ovf();
`ifdef SUB_OVF_FLAG_EN
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    b_in      = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_ovf();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
